// File: rtl/unary_add_multi.sv
// unary_add_multi: multi-channel serial unary accumulator.
// Counts the 1s on N_CH unary input streams while read_or_write is low
// (saturating at 2^CNT_W-1 with a sticky overflow flag C). When
// read_or_write goes high it replays the count as a thermometer stream on
// dout and then pulses done. en=0 freezes everything and masks done.
module unary_add_multi #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            read_or_write,
    input  logic [N_CH-1:0] din,
    output logic            dout,
    output logic            C,
    output logic            done
);

    // Five guard bits hold cnt + popcount(din) for up to 16 channels
    // without wrapping, so overflow can be seen before saturating.
    localparam int SUM_W = CNT_W + 5;
    localparam logic [SUM_W-1:0] CMAX = {5'b0, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EMIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               dout_q, dout_d;
    logic               c_q, c_d;
    logic               done_q, done_d;

    logic [SUM_W-1:0]   pop;
    logic [SUM_W-1:0]   sum;
    logic               sat;
    logic [CNT_W-1:0]   sat_cnt;

    // Population count of this cycle's inputs, added to the running count
    // (or to zero on the IDLE->ACC entry cycle), then clamped to CMAX.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            // NOTE: blocking '=' is right inside always_comb (values flow
            // top to bottom); clocked state below uses non-blocking '<='.
            pop = pop + SUM_W'(din[i]);
        end
        sum     = ((state_q == ACC) ? {5'b0, cnt_q} : '0) + pop;
        sat     = (sum > CMAX);
        sat_cnt = sat ? CMAX[CNT_W-1:0] : sum[CNT_W-1:0];
    end

    // Next-state and next-output logic; with en low everything holds and
    // done drops, so an en gap simply stretches the emitted pulse train.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dout_d  = dout_q;
        c_d     = c_q;
        done_d  = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    dout_d = 1'b0;
                    if (!read_or_write) begin
                        cnt_d   = sat_cnt;
                        c_d     = 1'b0;
                        state_d = ACC;
                    end
                end
                ACC: begin
                    if (!read_or_write) begin
                        cnt_d = sat_cnt;
                        if (sat) c_d = 1'b1;
                    end else begin
                        rem_d   = cnt_q;
                        dout_d  = 1'b0;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (!read_or_write) begin
                        // Abort: discard the sum without signalling done.
                        dout_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (rem_q != '0) begin
                        dout_d = 1'b1;
                        rem_d  = rem_q - 1'b1;
                    end else begin
                        dout_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    dout_d = 1'b0;
                    if (!read_or_write) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared immediately by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dout_q  <= 1'b0;
            c_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dout_q  <= dout_d;
            c_q     <= c_d;
            done_q  <= done_d;
        end
    end

    assign dout = dout_q;
    assign C    = c_q;
    assign done = done_q;

endmodule

// File: tb/tb_unary_add_multi.sv
// Testbench for unary_add_multi: stimulus pushes the expected emission
// length and overflow flag into a scoreboard; a monitor counts dout highs on
// enabled cycles and compares against the scoreboard on every done pulse.
module tb_unary_add_multi;

    localparam int N_CH  = 2;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            read_or_write;
    logic [N_CH-1:0] din;
    logic            dout;
    logic            C;
    logic            done;

    typedef struct {
        int n;
        int c;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   done_count = 0;
    int   high_cnt   = 0;
    int   total      = 0;
    logic en_s = 1'b0;
    logic rw_s = 1'b0;

    unary_add_multi #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .read_or_write (read_or_write),
        .din           (din),
        .dout          (dout),
        .C             (C),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs; return 1 time unit after the clock edge.
    task automatic drive(input logic e, input logic r, input logic [N_CH-1:0] d);
        en = e;
        read_or_write = r;
        din = d;
        @(posedge clk);
        #1;
    endtask

    // Accumulate n cycles from IDLE; modes: 0 all ones, 1 random with en
    // gaps, 2 all zeros, 3 the 01/10/00 rotation. Checks C every cycle.
    task automatic accumulate(input int n, input int mode);
        logic [N_CH-1:0] d;
        total = 0;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: d = '1;
                1: d = N_CH'($urandom);
                2: d = '0;
                default: d = (i % 3 == 0) ? 2'b01 : (i % 3 == 1) ? 2'b10 : 2'b00;
            endcase
            if (mode == 1 && i > 0 && $urandom_range(0, 3) == 0) begin
                drive(1'b0, 1'b0, ~d);
                check("c_frozen", int'(C), int'(total > CMAX));
            end
            drive(1'b1, 1'b0, d);
            total += $countones(d);
            check("c_during_acc", int'(C), int'(total > CMAX));
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.n = (total > CMAX) ? CMAX : total;
        e.c = (total > CMAX) ? 1 : 0;
        sb.push_back(e);
    endtask

    // Keep rw high (optionally with random en gaps) until the monitor has
    // seen done, bounded by a cycle budget.
    task automatic run_to_done(input int start, input bit gaps);
        for (int k = 0; k < 400 && done_count == start; k++)
            drive(gaps ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b1, N_CH'($urandom));
        if (done_count == start) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done pulse within 400 cycles (t=%0t)", $time);
        end
        drive(1'b1, 1'b1, N_CH'($urandom));
        check("hold_dout", int'(dout), 0);
        check("hold_done", int'(done), 0);
    endtask

    // HOLD -> IDLE takes one rw=0 cycle whose din must be ignored.
    task automatic leave_hold();
        drive(1'b1, 1'b0, '1);
    endtask

    // Capture the inputs seen at each active edge for the monitor.
    initial forever begin
        @(posedge clk);
        en_s = en;
        rw_s = read_or_write;
    end

    // Monitor: count emitted highs on enabled cycles; on done compare the
    // count and the overflow flag with the oldest scoreboard entry.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            high_cnt = 0;
        end else begin
            if (!rw_s) high_cnt = 0;
            else if (en_s && dout) high_cnt++;
            if (done) begin
                done_count++;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_done: done with nothing expected (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("emit_len", high_cnt, e.n);
                    check("ovf_at_done", int'(C), e.c);
                    check("dout_low_at_done", int'(dout), 0);
                end
                high_cnt = 0;
            end
        end
    end

    initial begin
        int start;
        rst_n = 1'b0;
        en = 1'b0;
        read_or_write = 1'b0;
        din = '0;
        #12;
        check("rst_dout", int'(dout), 0);
        check("rst_c", int'(C), 0);
        check("rst_done", int'(done), 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 19 cycles of 2'b11 -> 38 highs.
        accumulate(19, 0);
        push_expect();
        run_to_done(done_count, 1'b0);
        leave_hold();

        // 7 ones spread over 10 cycles.
        accumulate(10, 3);
        push_expect();
        run_to_done(done_count, 1'b0);
        leave_hold();

        // Overflow: 80 ones saturate at CMAX, C rises on the 32nd cycle.
        accumulate(40, 0);
        push_expect();
        run_to_done(done_count, 1'b0);
        leave_hold();

        // Empty sum: done on the second edge after rw rises; C cleared.
        accumulate(5, 2);
        push_expect();
        drive(1'b1, 1'b1, '0);
        check("zero_done_early", int'(done), 0);
        check("zero_dout_1", int'(dout), 0);
        drive(1'b1, 1'b1, '0);
        check("zero_done_pulse", int'(done), 1);
        check("zero_dout_2", int'(dout), 0);
        run_to_done(done_count - 1, 1'b0);
        leave_hold();

        // Sum of 10 with an en gap after 3 highs.
        accumulate(5, 0);
        push_expect();
        start = done_count;
        drive(1'b1, 1'b1, '0);
        check("gap_first_low", int'(dout), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, '0);
            check("gap_pre_high", int'(dout), 1);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, '0);
            check("gap_frozen_high", int'(dout), 1);
            check("gap_no_done", int'(done), 0);
        end
        run_to_done(start, 1'b0);
        leave_hold();

        // Abort after 5 highs; the next accumulation starts from zero.
        accumulate(4, 0);
        drive(1'b1, 1'b1, '0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, '0);
            check("abort_pre_high", int'(dout), 1);
        end
        drive(1'b1, 1'b0, '1);
        check("abort_dout", int'(dout), 0);
        check("abort_no_done", int'(done), 0);
        accumulate(2, 3);
        push_expect();
        run_to_done(done_count, 1'b0);
        leave_hold();

        // Random transactions with en gaps in both phases.
        for (int t = 0; t < 6; t++) begin
            accumulate($urandom_range(1, 40), 1);
            push_expect();
            run_to_done(done_count, 1'b1);
            leave_hold();
        end

        // Asynchronous reset mid-emission of a saturated sum.
        accumulate(40, 0);
        push_expect();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, '0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dout", int'(dout), 0);
        check("arst_c", int'(C), 0);
        check("arst_done", int'(done), 0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        accumulate(3, 0);
        push_expect();
        run_to_done(done_count, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expected emissions never completed", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
